shared_queue_arbiter: RTL
=========================

// Module: shared_queue_arbiter
// PURPOSE
//  Shares one CapQueue among N requesters. Round-robin arbiter picks one requester per cycle to enqueue.
//  Each entry carries a source tag. A per-requester occupancy quota stops any one source filling the queue.
//  Sits between N producer ports and a single consumer; the consumer sees data plus the source tag.
// PARAMETERS
//  N      4  number of requesters (>=2)
//  WIDTH  8  payload width per requester
//  DEPTH  4  queue depth in entries
//  QUOTA  2  max entries one requester may hold in the queue (1..DEPTH)
// PORTS
//  clk        in   1                      clock clk
//  reset      in   1                      reset reset, synchronous, active-low
//  req        in   N                      requester i has a valid payload
//  req_data   in   N*WIDTH                payload i at bits [i*WIDTH +: WIDTH]
//  gnt        out  N                      one-hot; payload i accepted this cycle
//  out_valid  out  1                      queue head valid (= !queue empty)
//  out_data   out  WIDTH                  head payload
//  out_src    out  clog2(N)               head source tag
//  out_deq    in   1                      consumer pops head; ignored when !out_valid
//  capacity   out  clog2(DEPTH+1)         free entries (queue capacity, passed through)
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - rr_ptr=0; every occ[i]=0; queue flushed, so capacity=DEPTH and out_valid=0 next cycle.
//   - gnt is forced to 0 combinationally while reset==0.
//   - Reset mid-operation discards all queued entries and counters in that one cycle; no partial state survives.
//  Eligibility:
//   - elig[i] = req[i] && occ[i] < QUOTA.
//   - Grants happen only when capacity != 0.
//   - No grant when full, even with a same-cycle out_deq; this costs one bubble cycle to keep gnt off the deq path.
//  Arbitration:
//   - Combinational same-cycle grant of the first eligible index searching rr_ptr, rr_ptr+1, ..., wrapping mod N.
//   - At most one gnt bit is set.
//   - On a grant to k: rr_ptr <= (k==N-1) ? 0 : k+1.
//   - With no grant, rr_ptr holds.
//  Enqueue:
//   - q_enq = |gnt; the queue stores {k, req_data[k]}.
//   - Entry becomes visible at the head no earlier than the next cycle (no bypass).
//   - A requester holding req after a grant presents its next payload; the grant is the accept handshake.
//  Dequeue:
//   - deq_fire = out_deq && out_valid; the popped tag s = out_src.
//  Occupancy update per i, evaluated in the same cycle:
//   - inc when gnt[i]; dec when deq_fire && s==i.
//   - Both inc and dec -> occ[i] unchanged; neither -> unchanged.
//   - occ never exceeds QUOTA and never underflows; either case is an assertion failure.
//  Invariants:
//   - sum(occ) + capacity == DEPTH every cycle after reset.
//   - out_src is always < N.
//  Widths:
//   - occ is clog2(QUOTA+1) bits; rr_ptr and tag are clog2(N) bits. All compares are unsigned.
// STRUCTURE
//  Package utils:
//   - clog2 (existing), plus a parameterised tag/entry struct {src, data}.
//  Sub-module:
//   - One CapQueue instance, width=WIDTH+clog2(N), depth=DEPTH, its active-high reset driven by !reset.
//  Local logic in this module:
//   - round-robin picker, rr_ptr register, occ[] counter array, SVA for the invariants above.
// TESTING (N=4, WIDTH=8, DEPTH=4, QUOTA=2)
//  1 Quota:
//    - req[1] held with data 0xA1 then 0xA2, no deq -> gnt[1] in 2 consecutive cycles, then 0.
//    - capacity 4->2; out_src=1, out_data=0xA1.
//  2 Fairness:
//    - req=4'b1111, no deq -> gnt order 0,1,2,3; then capacity=0 and gnt=0 while full.
//  3 Rotation:
//    - After a grant to 2, req=4'b1001 -> gnt[3] first, then gnt[0].
//  4 Simultaneous:
//    - occ[0]=1 with head src=0; req[0] and out_deq in the same cycle.
//    - Expect gnt[0]=1 and occ[0] stays 1; the popped value is the old head.
//  5 Full + deq:
//    - Queue full, req[2], out_deq=1 -> gnt=0 that cycle; gnt[2]=1 the next cycle.
//  6 Reset mid-op:
//    - 3 entries queued, reset=0 for 1 cycle with req active -> gnt=0.
//    - Next cycle out_valid=0, capacity=4, all occ=0, rr_ptr=0.

Source files
------------

// File: rtl/shared_queue_arbiter_pkg.sv
// Shared helpers for the shared_queue_arbiter slice.
//   clog2 : ceiling log2, minimum result 1, for sizing pointers, tags and counters.
package shared_queue_arbiter_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/shared_queue_arbiter_if.sv
// Producer/consumer bus of the shared queue arbiter.
//   req       : per-requester payload valid        (master -> slave)
//   req_data  : payload i at [i*WIDTH +: WIDTH]     (master -> slave)
//   gnt       : one-hot accept of a payload         (slave -> master)
//   out_valid : queue head valid                    (slave -> master)
//   out_data  : head payload                        (slave -> master)
//   out_src   : head source tag                     (slave -> master)
//   out_deq   : consumer pops the head              (master -> slave)
//   capacity  : free queue entries                  (slave -> master)
interface shared_queue_arbiter_if
    import shared_queue_arbiter_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned TAG_W = clog2(N);
    localparam int unsigned CAP_W = clog2(DEPTH + 1);

    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]       gnt;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_src;
    logic               out_deq;
    logic [CAP_W-1:0]   capacity;

    modport master (
        output req, req_data, out_deq,
        input  gnt, out_valid, out_data, out_src, capacity
    );

    modport slave (
        input  req, req_data, out_deq,
        output gnt, out_valid, out_data, out_src, capacity
    );
endinterface

// File: rtl/shared_queue_arbiter_capqueue.sv
// CapQueue: circular FIFO that reports its free-entry count.
//   clk_i, rst_i : clock, synchronous active-high flush
//   enq_i        : push enq_data_i (ignored when full)
//   deq_i        : pop head (ignored when empty)
//   deq_data_o   : head entry
//   empty_o      : no entries stored
//   capacity_o   : free entries, DEPTH when empty
module CapQueue
    import shared_queue_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        enq_i,
    input  logic [WIDTH-1:0]            enq_data_i,
    input  logic                        deq_i,
    output logic [WIDTH-1:0]            deq_data_o,
    output logic                        empty_o,
    output logic [clog2(DEPTH+1)-1:0]   capacity_o
);
    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned CAP_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CAP_W-1:0] cnt_q, cnt_d;
    logic             do_enq, do_deq;

    assign do_enq     = enq_i && (cnt_q != CAP_W'(DEPTH));
    assign do_deq     = deq_i && (cnt_q != '0);
    assign deq_data_o = mem_q[rd_q];
    assign empty_o    = (cnt_q == '0);
    assign capacity_o = CAP_W'(DEPTH) - cnt_q;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_enq) wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
        if (do_deq) rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
        if (do_enq && !do_deq) cnt_d = cnt_q + 1'b1;
        else if (do_deq && !do_enq) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the flushed pointers make stale words unreachable.
    always_ff @(posedge clk_i) begin
        if (do_enq) mem_q[wr_q] <= enq_data_i;
    end
endmodule

// File: rtl/shared_queue_arbiter.sv
// shared_queue_arbiter: round-robin sharing of one CapQueue among N producers,
// with a per-source occupancy quota; the consumer sees payload plus source tag.
//   clk   : clock
//   reset : synchronous, active-low
//   bus   : slave side of shared_queue_arbiter_if (req/req_data/gnt producer
//           handshake, out_valid/out_data/out_src/out_deq consumer, capacity)
module shared_queue_arbiter
    import shared_queue_arbiter_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned QUOTA = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    shared_queue_arbiter_if.slave  bus
);
    localparam int unsigned TAG_W = clog2(N);
    localparam int unsigned CAP_W = clog2(DEPTH + 1);
    localparam int unsigned OCC_W = clog2(QUOTA + 1);

    typedef struct packed {
        logic [TAG_W-1:0] src;
        logic [WIDTH-1:0] data;
    } entry_t;

    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [OCC_W-1:0] occ_q [N];
    logic [OCC_W-1:0] occ_d [N];
    logic [N-1:0]     elig, gnt, occ_inc, occ_dec;
    logic             grant_any;
    logic [TAG_W-1:0] grant_idx;
    logic             deq_fire, q_empty;
    logic [CAP_W-1:0] q_cap;
    entry_t           enq_entry, head_entry;
    int unsigned      occ_sum;

    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < N; i++)
            elig[i] = bus.req[i] && (occ_q[i] < OCC_W'(QUOTA));
    end

    // First eligible index from rr_ptr upward, wrapping; gated off while full
    // (even with a same-cycle pop) and while reset is asserted.
    always_comb begin
        int unsigned j;
        j         = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        gnt       = '0;
        if (reset && (q_cap != '0)) begin
            for (int unsigned off = 0; off < N; off++) begin
                j = int'(rr_ptr_q) + off;
                if (j >= N) j = j - N;
                if (!grant_any && elig[TAG_W'(j)]) begin
                    grant_any = 1'b1;
                    grant_idx = TAG_W'(j);
                end
            end
        end
        if (grant_any) gnt[grant_idx] = 1'b1;
    end

    assign enq_entry = '{src: grant_idx, data: bus.req_data[int'(grant_idx)*WIDTH +: WIDTH]};
    assign deq_fire  = bus.out_deq && !q_empty;

    CapQueue #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i      (clk),
        .rst_i      (!reset),
        .enq_i      (grant_any),
        .enq_data_i (enq_entry),
        .deq_i      (deq_fire),
        .deq_data_o (head_entry),
        .empty_o    (q_empty),
        .capacity_o (q_cap)
    );

    assign bus.gnt       = gnt;
    assign bus.out_valid = !q_empty;
    assign bus.out_data  = head_entry.data;
    assign bus.out_src   = head_entry.src;
    assign bus.capacity  = q_cap;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any) rr_ptr_d = (grant_idx == TAG_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        occ_inc = '0;
        occ_dec = '0;
        for (int unsigned i = 0; i < N; i++) begin
            occ_inc[i] = gnt[i];
            occ_dec[i] = deq_fire && (head_entry.src == TAG_W'(i));
            occ_d[i]   = occ_q[i];
            if (occ_inc[i] && !occ_dec[i])      occ_d[i] = occ_q[i] + 1'b1;
            else if (occ_dec[i] && !occ_inc[i]) occ_d[i] = occ_q[i] - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q <= '0;
            for (int unsigned i = 0; i < N; i++) occ_q[i] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int unsigned i = 0; i < N; i++) occ_q[i] <= occ_d[i];
        end
    end

    always_comb begin
        occ_sum = 0;
        for (int unsigned i = 0; i < N; i++) occ_sum = occ_sum + int'(occ_q[i]);
    end

    a_gnt_onehot: assert property (@(posedge clk) $onehot0(gnt));
    a_gnt_reset:  assert property (@(posedge clk) !reset |-> (gnt == '0));
    a_occ_sum:    assert property (@(posedge clk) disable iff (!reset)
                                   (occ_sum + int'(q_cap)) == DEPTH);
    a_src_range:  assert property (@(posedge clk) disable iff (!reset)
                                   !q_empty |-> (int'(head_entry.src) < N));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                a_occ_max:   assert (occ_q[i] <= OCC_W'(QUOTA));
                a_occ_over:  assert (!(occ_inc[i] && !occ_dec[i] && occ_q[i] == OCC_W'(QUOTA)));
                a_occ_under: assert (!(occ_dec[i] && !occ_inc[i] && occ_q[i] == '0));
            end
        end
    end
endmodule
